// File: rtl/icache_tag_ctrl_if.sv
// rtl/icache_tag_ctrl_if.sv - fetch/refill/flush handshake bundle for the icache tag controller
interface icache_tag_ctrl_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
) ();
  logic                   req_valid;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_ready;
  logic                   resp_valid;
  logic                   resp_hit;
  logic [INDEX_WIDTH-1:0] resp_index;
  logic                   fill_valid;
  logic [ADDR_WIDTH-1:0]  fill_addr;
  logic                   fill_ready;
  logic                   flush_req;
  logic                   busy;

  modport master (
    output req_valid, req_addr, fill_valid, fill_addr, flush_req,
    input  req_ready, resp_valid, resp_hit, resp_index, fill_ready, busy
  );

  modport slave (
    input  req_valid, req_addr, fill_valid, fill_addr, flush_req,
    output req_ready, resp_valid, resp_hit, resp_index, fill_ready, busy
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - icache tag RAM controller: clear sweep, fills, hit/miss lookups
// Optional hit/miss statistics counters under `ICACHE_TAG_STATS_EN.
module icache_tag_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  icache_tag_ctrl_if.slave                            bus,
  output logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH:0] tag_wr_data,
  output logic [INDEX_WIDTH-1:0]                      tag_wr_addr,
  output logic                                        tag_wr_en,
  output logic [INDEX_WIDTH-1:0]                      tag_rd_addr,
  input  logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH:0] tag_rd_data,
  output logic [31:0]                                 hit_cnt,
  output logic [31:0]                                 miss_cnt
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [TAG_WIDTH-1:0]   req_tag_q;
  logic [INDEX_WIDTH-1:0] resp_index_q;
  logic                   resp_valid_q;
  logic                   req_ready;
  logic                   fill_ready;
  logic                   flush_fire;
  logic                   lookup_fire;
  logic                   resp_hit;

  logic [INDEX_WIDTH-1:0] req_index, fill_index;
  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;

  assign req_index  = bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag    = bus.req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign fill_index = bus.fill_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign fill_tag   = bus.fill_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  // Byte-offset bits never matter to the tag store.
  logic unused_offset_bits;
  assign unused_offset_bits = &{1'b0, bus.req_addr[OFFSET_WIDTH-1:0], bus.fill_addr[OFFSET_WIDTH-1:0]};

  assign flush_fire  = (state_q == ST_RUN) && bus.flush_req;
  assign lookup_fire = bus.req_valid && req_ready;
  assign tag_rd_addr = req_index;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_wr_en   = 1'b0;
    tag_wr_addr = '0;
    tag_wr_data = '0;
    fill_ready  = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
      ST_CLEAR: begin
        tag_wr_en   = 1'b1;
        tag_wr_addr = idx_q;
        idx_d       = idx_q + 1'b1;
        if (idx_q == {INDEX_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_fire) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end else begin
          // Fill takes the cycle, so a read never collides with a write.
          fill_ready = 1'b1;
          req_ready  = !bus.fill_valid;
          if (bus.fill_valid) begin
            tag_wr_en   = 1'b1;
            tag_wr_addr = fill_index;
            tag_wr_data = {1'b1, fill_tag};
          end
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_index_q <= '0;
      req_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      resp_valid_q <= lookup_fire;
      if (lookup_fire) begin
        req_tag_q    <= req_tag;
        resp_index_q <= req_index;
      end
    end
  end

  // RAM has no output register, so the compare runs on the raw read data.
  assign resp_hit = resp_valid_q && tag_rd_data[TAG_WIDTH] &&
                    (tag_rd_data[TAG_WIDTH-1:0] == req_tag_q);

  assign bus.req_ready  = req_ready;
  assign bus.fill_ready = fill_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit;
  assign bus.resp_index = resp_index_q;
  assign bus.busy       = (state_q != ST_RUN);

`ifdef ICACHE_TAG_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_fire) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (resp_valid_q && resp_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (resp_valid_q && !resp_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - scoreboard bench for icache_tag_ctrl with a behavioural tag RAM
module tb_icache_tag_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] tag_wr_data;
  logic [7:0]  tag_wr_addr;
  logic        tag_wr_en;
  logic [7:0]  tag_rd_addr;
  logic [20:0] tag_rd_data;
  logic [31:0] hit_cnt, miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  icache_tag_ctrl_if #(.ADDR_WIDTH(32), .INDEX_WIDTH(8)) bus ();

  icache_tag_ctrl #(.ADDR_WIDTH(32), .INDEX_WIDTH(8), .OFFSET_WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .tag_wr_data (tag_wr_data),
    .tag_wr_addr (tag_wr_addr),
    .tag_wr_en   (tag_wr_en),
    .tag_rd_addr (tag_rd_addr),
    .tag_rd_data (tag_rd_data),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  logic [20:0] ram [256];
  always @(posedge clk) begin
    if (tag_wr_en) ram[tag_wr_addr] <= tag_wr_data;
    tag_rd_data <= ram[tag_rd_addr];
  end

  logic        m_valid [256];
  logic [19:0] m_tag   [256];
  logic [8:0]  exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_resp(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[11:4];
    return {m_valid[idx] && (m_tag[idx] == a[31:12]), idx};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
      else check("resp", {bus.resp_hit, bus.resp_index}, exp_q.pop_front());
    end
  end

  // Clear-sweep write monitor
  int   sweep_n = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_busy && !bus.busy) check("sweep_len", sweep_n, 256);
    if (!rst_n || !bus.busy) sweep_n = 0;
    else if (tag_wr_en) begin
      check("sweep_wr", {tag_wr_addr, tag_wr_data}, {sweep_n[7:0], 21'h0});
      sweep_n++;
    end
    prev_busy = bus.busy;
  end

  task automatic lookup(input logic [31:0] a);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) check("lookup_timeout", 0, 1);
    exp_q.push_back(model_resp(a));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("resp_latency", bus.resp_valid, 1);
  endtask

  task automatic fill(input logic [31:0] a);
    int n = 0;
    bus.fill_valid = 1'b1;
    bus.fill_addr  = a;
    #1;
    while (!bus.fill_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) check("fill_timeout", 0, 1);
    m_valid[a[11:4]] = 1'b1;
    m_tag[a[11:4]]   = a[31:12];
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 400) begin
      cnt++; @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) check("drain_timeout", 0, 1);
  endtask

  task automatic do_flush(input string name);
    int cnt;
    bus.flush_req = 1'b1;
    model_clear();
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    count_busy(cnt);
    check(name, cnt, 256);
  endtask

  initial begin
    int cnt;
    int n;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.flush_req  = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_fill_ready", bus.fill_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_hit", bus.resp_hit, 0);
    check("rst_resp_index", bus.resp_index, 0);
    check("rst_wr_en", tag_wr_en, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);

    rst_n = 1'b1;
    count_busy(cnt);
    check("busy_after_reset", cnt, 257);
    check("req_ready_run", bus.req_ready, 1);

    lookup(32'h0000_1230);
    fill(32'h1234_5670);
    lookup(32'h1234_567C);
    lookup(32'hABCD_5670);
    drain();

    // Fill and lookup presented together: fill wins, lookup follows
    bus.fill_valid = 1'b1;
    bus.fill_addr  = 32'h0000_0450;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_045C;
    #1;
    check("req_ready_blocked", bus.req_ready, 0);
    check("fill_ready_prio", bus.fill_ready, 1);
    m_valid[8'h45] = 1'b1;
    m_tag[8'h45]   = 20'h00000;
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
    #1;
    check("req_ready_after_fill", bus.req_ready, 1);
    exp_q.push_back(model_resp(32'h0000_045C));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();

    // Lookup immediately followed by flush answers from old contents
    lookup(32'h1234_5670);
    bus.flush_req = 1'b1;
    #1;
    check("flush_blocks_req", bus.req_ready, 0);
    do_flush("busy_after_flush");
    lookup(32'h1234_5670);
    drain();

    // Flush pulsed mid-sweep must not extend the sweep
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 400) begin
      bus.flush_req = (cnt == 50);
      cnt++; @(posedge clk); #1;
    end
    bus.flush_req = 1'b0;
    check("busy_flush_mid_sweep", cnt, 256);

    check("hit_cnt_after_flush", hit_cnt, 0);
    check("miss_cnt_after_flush", miss_cnt, 0);
    fill(32'h0000_0100);
    fill(32'h0000_0200);
    lookup(32'h0000_0100);
    lookup(32'h0000_0104);
    lookup(32'h0000_0200);
    lookup(32'h0000_0300);
    lookup(32'h8000_0100);
    drain();
    @(posedge clk); #1;
`ifdef ICACHE_TAG_STATS_EN
    check("hit_cnt_3", hit_cnt, 3);
    check("miss_cnt_2", miss_cnt, 2);
`else
    check("hit_cnt_tied", hit_cnt, 0);
    check("miss_cnt_tied", miss_cnt, 0);
`endif
    do_flush("busy_flush_stats");
    check("hit_cnt_cleared", hit_cnt, 0);
    check("miss_cnt_cleared", miss_cnt, 0);

`ifdef ICACHE_TAG_STATS_EN
    force dut.hit_cnt_q  = 32'hFFFF_FFFE;
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.hit_cnt_q;
    release dut.miss_cnt_q;
    fill(32'h0000_0100);
    lookup(32'h0000_0100);
    lookup(32'h0000_0100);
    lookup(32'h0000_0100);
    lookup(32'h0000_0700);
    lookup(32'h0000_0800);
    drain();
    @(posedge clk); #1;
    check("hit_cnt_sat", hit_cnt, 32'hFFFF_FFFF);
    check("miss_cnt_sat", miss_cnt, 32'hFFFF_FFFF);
`endif

    // Reset in the middle of a sweep restarts it from index 0
    bus.flush_req = 1'b1;
    model_clear();
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    n = 0;
    while (sweep_n < 100 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (n == 400) check("sweep100_timeout", 0, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_busy", bus.busy, 1);
    check("midrst_wr_en", tag_wr_en, 0);
    exp_q.delete();
    rst_n = 1'b1;
    count_busy(cnt);
    check("busy_after_midrst", cnt, 257);
    lookup(32'h0000_0100);
    drain();
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Controller for the single-port-write / single-port-read instruction-cache tag RAM: 256 entries × 21 bits, with 1-cycle read latency and no output register. It owns all tag RAM ports. It clears every entry after reset and on flush, serves hit/miss lookups from the fetch unit, and writes tags on line fills from the refill engine. It sits between the fetch pipeline, the refill engine and the tag RAM instance.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width.
- INDEX_WIDTH, 8, tag RAM address width (2^INDEX_WIDTH entries).
- OFFSET_WIDTH, 4, byte offset within a line (16-byte lines).
- Derived: TAG_WIDTH = ADDR_WIDTH − INDEX_WIDTH − OFFSET_WIDTH (20). RAM word = {valid, tag} = TAG_WIDTH+1 (21).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  lookup request.
- req_addr  in  ADDR_WIDTH  lookup address.
- req_ready  out  1  lookup accepted when req_valid & req_ready.
- resp_valid  out  1  lookup result valid.
- resp_hit  out  1  1 = entry valid and tag matched.
- resp_index  out  INDEX_WIDTH  index of the answered lookup.
- fill_valid  in  1  write tag for fill_addr as valid.
- fill_addr  in  ADDR_WIDTH  filled line address.
- fill_ready  out  1  fill accepted when fill_valid & fill_ready.
- flush_req  in  1  invalidate-all request, single-cycle pulse.
- busy  out  1  clear sweep in progress (or in reset).
- tag_wr_data  out  TAG_WIDTH+1  to RAM wr_data.
- tag_wr_addr  out  INDEX_WIDTH  to RAM wr_addr.
- tag_wr_en  out  1  to RAM wr_en.
- tag_rd_addr  out  INDEX_WIDTH  to RAM rd_addr.
- tag_rd_data  in  TAG_WIDTH+1  from RAM rd_data.
- hit_cnt, miss_cnt  out  32  statistics (see Configuration).

## Operation
- Address split: index = addr[OFFSET_WIDTH +: INDEX_WIDTH], tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH].
- FSM states:
  - RST: reset value. Nothing driven. Moves to CLEAR next cycle.
  - CLEAR: sweep counter idx from 0. Each cycle: tag_wr_en=1, tag_wr_addr=idx, tag_wr_data=0, idx++. After writing idx = 2^INDEX_WIDTH−1, go to RUN with idx=0.
  - RUN: normal service. flush_req=1 moves to CLEAR next cycle.
- flush_req is ignored in RST and CLEAR; the sweep does not restart.
- Priority in RUN: flush_req > fill > lookup.
  - fill_ready = RUN & !flush_req.
  - req_ready = RUN & !flush_req & !fill_valid.
- Fill: tag_wr_en=1, tag_wr_addr=fill index, tag_wr_data={1'b1, fill tag}. Written the same cycle it is accepted.
- Lookup: tag_rd_addr = req_addr index, combinational. Request tag and index are registered on acceptance.
- Compare: resp_hit = tag_rd_data[TAG_WIDTH] & (tag_rd_data[TAG_WIDTH-1:0] == registered tag).
- tag_rd_addr is don't-care when no lookup is accepted.
- busy = (state != RUN).

## Timing
- Reset values:
  - state RST, busy=1.
  - req_ready=0, fill_ready=0.
  - resp_valid=0, resp_hit=0, resp_index=0.
  - tag_wr_en=0, counters=0.
- After the first edge with rst_n=1: RST for 1 cycle, then CLEAR for 256 cycles. RUN is reached in cycle 258; req_ready is first high that cycle.
- Lookup latency 1: accepted at cycle N → resp_valid=1 in cycle N+1, resp_hit combinational from tag_rd_data. Back-to-back lookups give one response per cycle.
- Fill accepted in cycle N is visible to a lookup accepted in N+1. Fill and lookup are never issued to the RAM in the same cycle, so read/write collision is impossible by construction.
- Flush:
  - A lookup accepted in cycle N−1 still responds in cycle N (flush cycle), using pre-flush contents.
  - The sweep starts in N+1. Total unavailability is 256 cycles after the flush cycle.
- rst_n low mid-sweep or mid-lookup: next state RST, resp_valid=0 next cycle, the sweep restarts from 0.

## Configuration
- ICACHE_TAG_STATS_EN defined:
  - hit_cnt increments on each resp_valid & resp_hit; miss_cnt increments on each resp_valid & !resp_hit.
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear on reset and in the cycle the flush is accepted.
- Not defined: counter logic is removed and hit_cnt/miss_cnt are tied to 0. The port list is unchanged.

## Test plan
- Reset release → busy=1 for exactly 257 cycles, 256 writes of data 0 to addresses 0..255 in order, then req_ready=1. A lookup at 0x0000_1230 → resp_valid next cycle, resp_hit=0, resp_index=0x23.
- Fill 0x1234_5670, then lookup 0x1234_567C next cycle → resp_hit=1, resp_index=0x67. Lookup 0xABCD_5670 → resp_hit=0 (same index, tag mismatch).
- Simultaneous fill_valid and req_valid → fill written, req_ready=0 that cycle. The lookup is accepted the following cycle and hits.
- Lookup accepted, then flush_req next cycle → the pending response reports hit=1 from old contents. busy high 256 cycles. A later lookup of the same line → hit=0. flush_req pulsed mid-sweep → sweep length unchanged.
- rst_n low for 1 cycle at sweep index 100 → sweep restarts at 0, resp_valid=0.
- With ICACHE_TAG_STATS_EN: 3 hits and 2 misses → hit_cnt=3, miss_cnt=2. After a flush, both are 0. Counters preloaded near saturation via a force → they hold at 0xFFFF_FFFF.
